// File: rtl/csa_tree_pipe_pkg.sv
// Shared helpers for the carry-save adder tree: level counting, output width
// and per-level operand counts, evaluated at elaboration time.
package csa_pkg;

   localparam int SHA_W = 32;

   // Operand count left after l levels of 3:2 reduction, starting from n.
   function automatic int level_n(int n, int l);
      int cnt;
      cnt = n;
      for (int i = 0; i < l; i++) begin
         if (cnt > 2) cnt = cnt - cnt / 3;
      end
      return cnt;
   endfunction

   // Number of 3:2 levels needed to bring n operands down to two.
   function automatic int csa_levels(int n);
      int cnt;
      int lv;
      cnt = n;
      lv  = 0;
      while (cnt > 2) begin
         cnt = cnt - cnt / 3;
         lv++;
      end
      return lv;
   endfunction

   // Result width: modular sums keep the operand width, full sums grow by log2(n).
   function automatic int csa_width(int w, int n, bit mod);
      return mod ? w : w + $clog2(n);
   endfunction

endpackage

// File: rtl/csa_tree_pipe_if.sv
// Valid/ready bundle for the multi-operand adder: an operand set goes in,
// one sum comes out. The producer/consumer side uses master, the adder uses slave.
interface csa_tree_pipe_if
   import csa_pkg::*;
#(
   parameter int WIDTH    = SHA_W,
   parameter int N_OPS    = 7,
   parameter bit MODE_MOD = 1'b1
);

   localparam int OUT_W = csa_width(WIDTH, N_OPS, MODE_MOD);

   logic                   in_valid;
   logic                   in_ready;
   logic [N_OPS*WIDTH-1:0] in_ops;
   logic                   out_valid;
   logic                   out_ready;
   logic [OUT_W-1:0]       out_sum;

   modport master (
      output in_valid, in_ops, out_ready,
      input  in_ready, out_valid, out_sum
   );

   modport slave (
      input  in_valid, in_ops, out_ready,
      output in_ready, out_valid, out_sum
   );

endinterface

// File: rtl/csa_tree_pipe_csa32.sv
// Combinational W-bit 3:2 compressor: three addends become a sum vector and a
// carry vector whose total equals a+b+c (modulo 2^W).
module csa32 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   assign sum   = a ^ b ^ c;
   assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand adder. Each 3:2 reduction level is one register
// stage and the final carry-propagate add is one more, so the pipe holds
// LEVELS+1 results. Stall propagates combinationally from out_ready back to
// in_ready, so empty stages are filled even while the output is blocked.
module csa_tree_pipe
   import csa_pkg::*;
#(
   parameter int WIDTH    = SHA_W,
   parameter int N_OPS    = 7,
   parameter bit MODE_MOD = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   csa_tree_pipe_if.slave  bus
);

   localparam int OUT_W  = csa_width(WIDTH, N_OPS, MODE_MOD);
   localparam int LEVELS = csa_levels(N_OPS);

   logic [LEVELS:0]  v;
   logic [LEVELS:0]  load;
   logic [LEVELS:0]  take;
   logic [OUT_W-1:0] cpa_a;
   logic [OUT_W-1:0] cpa_b;
   logic [OUT_W-1:0] sum_q;

   // Ready chain from the output back to the input; take marks a stage that captures valid data.
   always_comb begin : ready_chain
      logic downstream;
      load       = '0;
      take       = '0;
      downstream = bus.out_ready;
      for (int s = LEVELS; s >= 0; s--) begin
         load[s] = !v[s] || downstream;
         if (s > 0) begin
            take[s]    = v[s-1] && load[s];
            downstream = take[s];
         end
      end
      take[0] = bus.in_valid && load[0] && !rst;
   end

   assign bus.in_ready = load[0] && !rst;

   // Stage valid bits: a loading stage inherits the valid of whatever it captures.
   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
      end else begin
         for (int s = 0; s <= LEVELS; s++) begin
            if (load[s]) v[s] <= take[s];
         end
      end
   end

   for (genvar l = 0; l < LEVELS; l++) begin : lvl
      localparam int NI = level_n(N_OPS, l);
      localparam int NO = level_n(N_OPS, l + 1);
      localparam int NG = NI / 3;

      logic [OUT_W-1:0] din  [NI];
      logic [OUT_W-1:0] dout [NO];
      logic [OUT_W-1:0] q    [NO];

      if (l == 0) begin : src
         for (genvar k = 0; k < NI; k++) begin : ext
            assign din[k] = OUT_W'(bus.in_ops[k*WIDTH +: WIDTH]);
         end
      end else begin : src
         for (genvar k = 0; k < NI; k++) begin : fwd
            assign din[k] = lvl[l-1].q[k];
         end
      end

      for (genvar g = 0; g < NG; g++) begin : cmp
         csa32 #(.W(OUT_W)) u_csa (
            .a     (din[3*g]),
            .b     (din[3*g+1]),
            .c     (din[3*g+2]),
            .sum   (dout[2*g]),
            .carry (dout[2*g+1])
         );
      end

      for (genvar k = 3*NG; k < NI; k++) begin : pass
         assign dout[k-NG] = din[k];
      end

      // Level register: captures the reduced vectors only when valid data advances into it.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int k = 0; k < NO; k++) q[k] <= '0;
         end else if (take[l]) begin
            for (int k = 0; k < NO; k++) q[k] <= dout[k];
         end
      end
   end

   if (LEVELS == 0) begin : cpa_src
      assign cpa_a = OUT_W'(bus.in_ops[0 +: WIDTH]);
      assign cpa_b = OUT_W'(bus.in_ops[WIDTH +: WIDTH]);
   end else begin : cpa_src
      assign cpa_a = lvl[LEVELS-1].q[0];
      assign cpa_b = lvl[LEVELS-1].q[1];
   end

   // Final carry-propagate add; held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else if (take[LEVELS]) begin
         sum_q <= cpa_a + cpa_b;
      end
   end

   assign bus.out_valid = v[LEVELS];
   assign bus.out_sum   = sum_q;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Self-checking bench for csa_tree_pipe: a 7-operand SHA-width instance with a
// scoreboard, plus full-precision, 2-operand and 5-operand instances.
module tb_csa_tree_pipe;
   import csa_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   csa_tree_pipe_if #(.WIDTH(32), .N_OPS(7), .MODE_MOD(1'b1)) bus7     ();
   csa_tree_pipe_if #(.WIDTH(32), .N_OPS(7), .MODE_MOD(1'b0)) bus_full ();
   csa_tree_pipe_if #(.WIDTH(32), .N_OPS(2), .MODE_MOD(1'b1)) bus_two  ();
   csa_tree_pipe_if #(.WIDTH(32), .N_OPS(5), .MODE_MOD(1'b1)) bus_five ();

   csa_tree_pipe #(.WIDTH(32), .N_OPS(7), .MODE_MOD(1'b1)) u_dut  (.clk(clk), .rst(rst), .bus(bus7));
   csa_tree_pipe #(.WIDTH(32), .N_OPS(7), .MODE_MOD(1'b0)) u_full (.clk(clk), .rst(rst), .bus(bus_full));
   csa_tree_pipe #(.WIDTH(32), .N_OPS(2), .MODE_MOD(1'b1)) u_two  (.clk(clk), .rst(rst), .bus(bus_two));
   csa_tree_pipe #(.WIDTH(32), .N_OPS(5), .MODE_MOD(1'b1)) u_five (.clk(clk), .rst(rst), .bus(bus_five));

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] exp_q [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_sum7(logic [223:0] ops);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < 7; k++) s = s + ops[k*32 +: 32];
      return s;
   endfunction

   task automatic aux_drive(int which, logic valid, logic [223:0] ops);
      case (which)
         0: begin bus7.in_valid = valid;     bus7.in_ops = ops;               bus7.out_ready = 1'b1;     end
         1: begin bus_full.in_valid = valid; bus_full.in_ops = ops;           bus_full.out_ready = 1'b1; end
         2: begin bus_two.in_valid = valid;  bus_two.in_ops = ops[63:0];      bus_two.out_ready = 1'b1;  end
         default: begin bus_five.in_valid = valid; bus_five.in_ops = ops[159:0]; bus_five.out_ready = 1'b1; end
      endcase
   endtask

   function automatic logic aux_ready(int which);
      case (which)
         0:       return bus7.in_ready;
         1:       return bus_full.in_ready;
         2:       return bus_two.in_ready;
         default: return bus_five.in_ready;
      endcase
   endfunction

   function automatic logic aux_valid(int which);
      case (which)
         0:       return bus7.out_valid;
         1:       return bus_full.out_valid;
         2:       return bus_two.out_valid;
         default: return bus_five.out_valid;
      endcase
   endfunction

   function automatic logic [34:0] aux_sum(int which);
      case (which)
         0:       return {3'b000, bus7.out_sum};
         1:       return bus_full.out_sum;
         2:       return {3'b000, bus_two.out_sum};
         default: return {3'b000, bus_five.out_sum};
      endcase
   endfunction

   task automatic test_reset();
      int  ever_valid;
      bus7.in_valid  = 1'b1;
      bus7.in_ops    = {7{32'h1111_1111}};
      bus7.out_ready = 1'b1;
      rst = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         compared++;
         if (bus7.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", bus7.out_valid);
         end
         compared++;
         if (bus7.out_sum !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_out_sum: got %h expected 00000000", bus7.out_sum);
         end
         compared++;
         if (bus7.in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", bus7.in_ready);
         end
         tick();
      end
      rst = 1'b0;
      bus7.in_valid = 1'b0;
      @(negedge clk);
      compared++;
      if (bus7.in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL release_in_ready: got %b expected 1", bus7.in_ready);
      end
      ever_valid = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         @(negedge clk);
         if (bus7.out_valid !== 1'b0) ever_valid++;
      end
      compared++;
      if (ever_valid != 0) begin
         mismatched++;
         $display("[TB] FAIL reset_ghost: got %0d outputs expected 0", ever_valid);
      end
      tick();
   endtask

   task automatic test_single(int which, logic [223:0] ops, logic [34:0] exp, int exp_lat, string name);
      int lat;
      bit seen;
      aux_drive(which, 1'b1, ops);
      @(negedge clk);
      compared++;
      if (aux_ready(which) !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL %s_accept: in_ready %b expected 1", name, aux_ready(which));
      end
      tick();
      aux_drive(which, 1'b0, ops);
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat <= 20) begin
         @(negedge clk);
         if (aux_valid(which) === 1'b1) seen = 1'b1;
         else begin
            tick();
            lat++;
         end
      end
      compared++;
      if (!seen || lat != exp_lat) begin
         mismatched++;
         $display("[TB] FAIL %s_latency: got %0d (seen %0d) expected %0d", name, lat, seen, exp_lat);
      end
      compared++;
      if (aux_sum(which) !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s_sum: got %h expected %h", name, aux_sum(which), exp);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int sent = 0, got = 0, cyc = 0, last_out = -1;
      bit stalled = 1'b0, gap = 1'b0;
      logic [31:0] exp;
      exp_q.delete();
      bus7.out_ready = 1'b1;
      while (got < 20 && cyc < 200) begin
         if (sent < 20) begin
            bus7.in_valid = 1'b1;
            for (int k = 0; k < 7; k++) bus7.in_ops[k*32 +: 32] = 32'(sent + k);
         end else begin
            bus7.in_valid = 1'b0;
         end
         @(negedge clk);
         if (bus7.in_valid && !bus7.in_ready) stalled = 1'b1;
         if (bus7.in_valid && bus7.in_ready) begin
            exp_q.push_back(32'(7 * sent + 21));
            sent++;
         end
         if (bus7.out_valid && bus7.out_ready) begin
            if (last_out >= 0 && cyc != last_out + 1) gap = 1'b1;
            last_out = cyc;
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL b2b_spurious: got %h expected no output", bus7.out_sum);
            end else begin
               exp = exp_q.pop_front();
               if (bus7.out_sum !== exp) begin
                  mismatched++;
                  $display("[TB] FAIL b2b_sum: got %h expected %h", bus7.out_sum, exp);
               end
            end
            got++;
         end
         tick();
         cyc++;
      end
      bus7.in_valid = 1'b0;
      compared++;
      if (got != 20) begin
         mismatched++;
         $display("[TB] FAIL b2b_count: got %0d expected 20", got);
      end
      compared++;
      if (stalled) begin
         mismatched++;
         $display("[TB] FAIL b2b_in_ready: got 0 during stream expected 1");
      end
      compared++;
      if (gap) begin
         mismatched++;
         $display("[TB] FAIL b2b_rate: got gapped outputs expected one per cycle");
      end
   endtask

   task automatic test_backpressure();
      int accepts = 0, got = 0;
      bit held = 1'b0, stable = 1'b1;
      logic [31:0] hold_val = '0, exp;
      exp_q.delete();
      bus7.out_ready = 1'b0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         bus7.in_valid = 1'b1;
         for (int k = 0; k < 7; k++) bus7.in_ops[k*32 +: 32] = 32'(1000 * accepts + k * 3);
         @(negedge clk);
         if (bus7.in_valid && bus7.in_ready) begin
            exp_q.push_back(ref_sum7(bus7.in_ops));
            accepts++;
         end
         if (bus7.out_valid) begin
            if (!held) begin
               held     = 1'b1;
               hold_val = bus7.out_sum;
            end else if (bus7.out_sum !== hold_val) stable = 1'b0;
         end
         tick();
      end
      @(negedge clk);
      compared++;
      if (accepts != 5) begin
         mismatched++;
         $display("[TB] FAIL bp_accepts: got %0d expected 5", accepts);
      end
      compared++;
      if (bus7.in_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL bp_in_ready: got %b expected 0", bus7.in_ready);
      end
      compared++;
      if (!held || !stable) begin
         mismatched++;
         $display("[TB] FAIL bp_hold: held %0d stable %0d expected 1 1", held, stable);
      end
      tick();
      bus7.in_valid  = 1'b0;
      bus7.out_ready = 1'b1;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge clk);
         if (bus7.out_valid && bus7.out_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL bp_spurious: got %h expected no output", bus7.out_sum);
            end else begin
               exp = exp_q.pop_front();
               if (bus7.out_sum !== exp) begin
                  mismatched++;
                  $display("[TB] FAIL bp_sum: got %h expected %h", bus7.out_sum, exp);
               end
            end
            got++;
         end
         tick();
      end
      compared++;
      if (got != 5) begin
         mismatched++;
         $display("[TB] FAIL bp_drain: got %0d results expected 5", got);
      end
   endtask

   task automatic test_random();
      int sent = 0, got = 0, cyc = 0;
      logic [31:0] exp;
      exp_q.delete();
      while ((sent < 10000 || got < sent) && cyc < 60000) begin
         bus7.in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 7; k++) bus7.in_ops[k*32 +: 32] = $urandom();
         bus7.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus7.in_valid && bus7.in_ready) begin
            exp_q.push_back(ref_sum7(bus7.in_ops));
            sent++;
         end
         if (bus7.out_valid && bus7.out_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL rand_spurious: got %h expected no output", bus7.out_sum);
            end else begin
               exp = exp_q.pop_front();
               if (bus7.out_sum !== exp) begin
                  mismatched++;
                  $display("[TB] FAIL rand_sum: got %h expected %h", bus7.out_sum, exp);
               end
            end
            got++;
         end
         tick();
         cyc++;
      end
      bus7.in_valid  = 1'b0;
      bus7.out_ready = 1'b1;
      compared++;
      if (sent != 10000 || got != sent) begin
         mismatched++;
         $display("[TB] FAIL rand_count: got in %0d out %0d expected 10000 10000", sent, got);
      end
   endtask

   task automatic test_reset_flush();
      int accepts = 0, emitted = 0;
      exp_q.delete();
      bus7.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus7.in_valid = 1'b1;
         for (int k = 0; k < 7; k++) bus7.in_ops[k*32 +: 32] = 32'(50 + i + k);
         @(negedge clk);
         if (bus7.in_valid && bus7.in_ready) accepts++;
         tick();
      end
      compared++;
      if (accepts != 3) begin
         mismatched++;
         $display("[TB] FAIL flush_fill: got %0d accepts expected 3", accepts);
      end
      bus7.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus7.out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus7.out_valid !== 1'b0) emitted++;
         tick();
      end
      compared++;
      if (emitted != 0) begin
         mismatched++;
         $display("[TB] FAIL flush_ghost: got %0d outputs expected 0", emitted);
      end
      test_single(0, {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 35'd28, 5, "flush_next");
   endtask

   initial begin
      logic [31:0] t1;
      rst = 1'b1;
      aux_drive(0, 1'b0, '0);
      aux_drive(1, 1'b0, '0);
      aux_drive(2, 1'b0, '0);
      aux_drive(3, 1'b0, '0);

      test_reset();
      test_single(0, {7{32'hFFFF_FFFF}}, 35'h0_FFFF_FFF9, 5, "mod_ones");
      test_single(1, {7{32'hFFFF_FFFF}}, 35'h6_FFFF_FFF9, 5, "full_ones");
      test_single(2, {160'd0, 32'hFFFF_FFFF, 32'd5}, 35'd4, 1, "two_ops");
      t1 = 32'h5be0cd19 + 32'h3587272b + 32'h1f85c98c + 32'h428a2f98 + 32'h61626380;
      test_single(3, {64'd0, 32'h61626380, 32'h428a2f98, 32'h1f85c98c, 32'h3587272b, 32'h5be0cd19},
                  {3'b000, t1}, 4, "sha_t1");
      test_single(3, {64'd0, {5{32'hFFFF_FFFF}}}, 35'h0_FFFF_FFFB, 4, "five_ones");
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_flush();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
